// File: rtl/tick_gen_pkg.sv
// Shared constants and the Hz-to-divisor helper for the tick generator.
package tick_gen_pkg;

  localparam int unsigned CLK_HZ    = 100000000;
  localparam int unsigned DEF_CNT_W = 27;

  // Divisor for a target rate; saturates at the widest counter value, hz=0 yields 0.
  function automatic int unsigned hz_to_div(input int unsigned hz);
    longint unsigned q;
    longint unsigned max_div;
    max_div = (64'd1 << DEF_CNT_W) - 64'd1;
    if (hz == 0) return 0;
    q = longint'(CLK_HZ) / longint'(hz);
    if (q > max_div) return int'(max_div);
    return int'(q);
  endfunction

  localparam int unsigned DEF_DIV_1HZ = hz_to_div(1);

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: divisor register, phase counter, registered tick (and wave when
// TICK_GEN_WAVE_EN is defined).
module tick_gen_ch #(
  parameter int unsigned CNT_W = 27,
  parameter logic [CNT_W-1:0] DEF_DIV = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] div,
`ifdef TICK_GEN_WAVE_EN
  output logic             wave,
`endif
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] d_eff;
  logic             restart;
  logic             terminal;

  // A stored divisor of zero behaves as one (tick every cycle).
  assign d_eff    = (div == '0) ? CNT_W'(1) : div;
  assign terminal = (cnt == d_eff - CNT_W'(1));
  assign restart  = !en || sync_clr || we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= DEF_DIV;
      cnt  <= '0;
      tick <= 1'b0;
`ifdef TICK_GEN_WAVE_EN
      wave <= 1'b0;
`endif
    end else begin
      if (we) div <= wdata;
      if (restart) begin
        cnt  <= '0;
        tick <= 1'b0;
`ifdef TICK_GEN_WAVE_EN
        wave <= 1'b0;
`endif
      end else if (terminal) begin
        cnt  <= '0;
        tick <= 1'b1;
`ifdef TICK_GEN_WAVE_EN
        wave <= ~wave;
`endif
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator with per-channel enable, phase restart and
// divisor read-back. Optional square-wave outputs under TICK_GEN_WAVE_EN.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = DEF_DIV_1HZ,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [CNT_W-1:0]  rd_div,
`ifdef TICK_GEN_WAVE_EN
  output logic [NUM_CH-1:0] wave,
`endif
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0] divs [NUM_CH];

  // Writes have no handshake: a strobe is taken every cycle it is high.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic we_g;
    assign we_g = cfg_we && (int'(cfg_ch) == g);

    tick_gen_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (CNT_W'(DEF_DIV))
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ch_en[g]),
      .sync_clr (sync_clr),
      .we       (we_g),
      .wdata    (cfg_div),
      .div      (divs[g]),
`ifdef TICK_GEN_WAVE_EN
      .wave     (wave[g]),
`endif
      .tick     (tick[g])
    );
  end

  // Out-of-range channel addresses read back as zero.
  always_comb begin
    rd_div = '0;
    if (int'(cfg_ch) < NUM_CH) rd_div = divs[cfg_ch];
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed scenarios plus random traffic
// against a phase-count reference model.
module tb_tick_gen_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 27;
  localparam int DEF_DIV = 10;
  localparam int CH_W    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_clr;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  rd_div;
  logic [NUM_CH-1:0] tick;
`ifdef TICK_GEN_WAVE_EN
  logic [NUM_CH-1:0] wave;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: running-edge count since the last restart, per channel.
  int unsigned       m_div   [NUM_CH];
  int unsigned       m_since [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_wave;

  always #5 clk = ~clk;

  tick_gen_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .rd_div   (rd_div),
`ifdef TICK_GEN_WAVE_EN
    .wave     (wave),
`endif
    .tick     (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]   = DEF_DIV;
      m_since[i] = 0;
    end
    m_tick = '0;
    m_wave = '0;
  endtask

  // Advance the model with the inputs present before the edge, then compare after it.
  task automatic cycle();
    for (int i = 0; i < NUM_CH; i++) begin
      int unsigned d;
      logic wr;
      d  = (m_div[i] == 0) ? 1 : m_div[i];
      wr = cfg_we && (int'(cfg_ch) == i);
      if (wr) m_div[i] = cfg_div;
      if (!ch_en[i] || sync_clr || wr) begin
        m_since[i] = 0;
        m_tick[i]  = 1'b0;
        m_wave[i]  = 1'b0;
      end else begin
        m_since[i]++;
        m_tick[i] = (m_since[i] % d) == 0;
        m_wave[i] = ((m_since[i] / d) % 2) == 1;
      end
    end
    @(posedge clk);
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("rd_div", 32'(rd_div), m_div[cfg_ch]);
`ifdef TICK_GEN_WAVE_EN
    check("wave", 32'(wave), 32'(m_wave));
`endif
  endtask

  task automatic write_div(input int ch, input int unsigned d);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = CNT_W'(d);
    cycle();
    cfg_we  = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    ch_en    = 4'b0001;
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_rd_div", 32'(rd_div), DEF_DIV);
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 0 with reset divisor 10 ticks on cycles 10, 20, 30.
    for (int n = 1; n <= 30; n++) begin
      cycle();
      check("t1_tick0", 32'(tick[0]), 32'((n % 10) == 0));
    end

    // Mid-count write of divisor 3 to channel 1.
    ch_en[1] = 1'b1;
    repeat (4) cycle();
    write_div(1, 3);
    check("t2_rd_div", 32'(rd_div), 32'd3);
    for (int k = 1; k <= 9; k++) begin
      cycle();
      check("t2_tick1", 32'(tick[1]), 32'((k % 3) == 0));
    end

    // Divisor 0 and 1 both give a continuously high tick while enabled.
    for (int v = 0; v <= 1; v++) begin
      ch_en[2] = 1'b1;
      write_div(2, v);
      for (int k = 0; k < 5; k++) begin
        cycle();
        check("t3_tick_high", 32'(tick[2]), 32'd1);
      end
      ch_en[2] = 1'b0;
      cycle();
      check("t3_tick_drop", 32'(tick[2]), 32'd0);
    end

    // Phase alignment of D=4 and D=6 by sync_clr.
    ch_en = 4'b0011;
    write_div(0, 4);
    write_div(1, 6);
    repeat (7) cycle();
    sync_clr = 1'b1;
    cycle();
    check("t4_clr_tick", 32'(tick), 32'h0);
    sync_clr = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      cycle();
      check("t4_tick0", 32'(tick[0]), 32'((k % 4) == 0));
      check("t4_tick1", 32'(tick[1]), 32'((k % 6) == 0));
    end

`ifdef TICK_GEN_WAVE_EN
    // Square wave with D=5 toggles every 5 cycles.
    ch_en = 4'b0001;
    write_div(0, 5);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      check("t6_wave0", 32'(wave[0]), 32'(((k / 5) % 2) == 1));
    end
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) ch_en = NUM_CH'($urandom);
      sync_clr = ($urandom_range(0, 15) == 0);
      cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_div  = CNT_W'($urandom_range(0, 9));
      cycle();
    end
    sync_clr = 1'b0;
    cfg_we   = 1'b0;

    // Asynchronous reset in the middle of a period.
    ch_en = 4'b0001;
    write_div(0, 7);
    repeat (3) cycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_async_tick", 32'(tick), 32'h0);
`ifdef TICK_GEN_WAVE_EN
    check("t5_async_wave", 32'(wave), 32'h0);
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_ch = CH_W'(i);
      #1;
      check("t5_rd_div", 32'(rd_div), DEF_DIV);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    cfg_ch = '0;
    for (int n = 1; n <= 12; n++) begin
      cycle();
      check("t5_tick0", 32'(tick[0]), 32'((n % 10) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
